// File: rtl/apb_req_pkg.sv
// Shared types and constants for the sel/enable requester slice.
// No logic; latency not applicable.
// No flow control; consumed by the interface, top and timer.
package apb_req_pkg;

  // Requester phase: IDLE waits for a command, SETUP drives sel alone,
  // ACCESS adds enable until the slave is ready, RESP holds the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int AW_DEF      = 4;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/apb_req_master_if.sv
// Bundles the command, response and slave-pin signals of the requester.
// Wires only; no latency.
// Carries the cmd valid/ready and rsp valid/ready handshakes unchanged.
interface apb_req_master_if
  import apb_req_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  // command port
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  // response port
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // slave pins
  logic          sel;
  logic          enable;
  logic          op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;

  // status
  logic          busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  rsp_ready, ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output sel, enable, op, addr, wdata, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output rsp_ready, ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sel, enable, op, addr, wdata, busy
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on the slave; flags the last allowed one.
// count updates one cycle after inc; expired decodes combinationally from count.
// No handshake: inc/clr are sampled every cycle, count saturates at all-ones.
module apb_wait_timer
  import apb_req_pkg::*;
#(
  parameter  int LIMIT = TIMEOUT_DEF,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          expired
);

  // Saturating wait counter, cleared on reset or when the transfer retires.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // The cycle holding LIMIT-1 is the last ACCESS cycle allowed without ready.
  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_req_master.sv
// Requester for the sel/enable slave: cmd -> SETUP -> ACCESS -> RESP; optional timeout via APB_REQ_MASTER_TIMEOUT_EN.
// sel at T+1, enable at T+2 after accept at T; rsp_valid one cycle after ready is sampled (min 3 cycles).
// One transfer in flight: cmd_ready only in IDLE; RESP holds until rsp_ready, stalling new commands.
module apb_req_master
  import apb_req_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  apb_req_master_if.master  bus
);

  state_t        state;
  state_t        state_nxt;
  logic          sel_nxt;
  logic          enable_nxt;
  logic          op_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_rdata_nxt;
  logic          rsp_err_nxt;
  logic          accept;
  logic          timeout_hit;

  // Only these two are decoded from state; everything else is a flop.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic [TCW-1:0] wait_cnt;
  logic           tmr_expired;
  logic           tmr_clr;
  logic           tmr_inc;

  assign tmr_clr = (state == RESP) && bus.rsp_ready;
  assign tmr_inc = (state == ACCESS) && !bus.ready;

  apb_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .count   (wait_cnt),
    .expired (tmr_expired)
  );

  // expired and the raw count describe the same cycle; require both to agree.
  assign timeout_hit = tmr_expired && (wait_cnt == TCW'(TIMEOUT - 1));
`else
  // Without the timer ACCESS waits forever; this compare is constant false.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next state and next values of the registered slave/response outputs.
  always_comb begin
    state_nxt     = state;
    sel_nxt       = 1'b0;
    enable_nxt    = 1'b0;
    op_nxt        = bus.op;
    addr_nxt      = bus.addr;
    wdata_nxt     = bus.wdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = bus.rsp_rdata;
    rsp_err_nxt   = bus.rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          sel_nxt   = 1'b1;
          op_nxt    = bus.cmd_op;
          addr_nxt  = bus.cmd_addr;
          wdata_nxt = bus.cmd_wdata;
        end
      end
      SETUP: begin
        state_nxt  = ACCESS;
        sel_nxt    = 1'b1;
        enable_nxt = 1'b1;
      end
      ACCESS: begin
        sel_nxt    = 1'b1;
        enable_nxt = 1'b1;
        // ready wins over a timeout landing in the same cycle
        if (bus.ready) begin
          state_nxt     = RESP;
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = (bus.op == OP_READ) ? bus.rdata : '0;
          rsp_err_nxt   = 1'b0;
        end else if (timeout_hit) begin
          state_nxt     = RESP;
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.sel       <= 1'b0;
      bus.enable    <= 1'b0;
      bus.op        <= 1'b0;
      bus.addr      <= '0;
      bus.wdata     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.sel       <= sel_nxt;
      bus.enable    <= enable_nxt;
      bus.op        <= op_nxt;
      bus.addr      <= addr_nxt;
      bus.wdata     <= wdata_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      bus.rsp_rdata <= rsp_rdata_nxt;
      bus.rsp_err   <= rsp_err_nxt;
    end
  end

endmodule
